rom_port_arbiter: RTL

- Shares one synchronous-read port of the 512x32 boot ROM between two requesters: r0, instruction fetch, and r1, data/bus load.
- Arbitration is round-robin with a req/gnt handshake.
- Tracks the ROM's one-cycle read latency, registers the returned word and tags it back to the requester that issued it.
- Sits between the CPU fetch/load paths and ROM port A. Port B stays unused by this block.

---
 rtl/rom_port_arbiter.sv | 127 ++++++++++++
 1 files changed

// File: rtl/rom_port_arbiter.sv
// Round-robin arbiter sharing one synchronous-read ROM port between fetch (r0) and load (r1).
// Define ROM_ARB_LOCK_EN to add r0_lock exclusive back-to-back access bounded by MAX_LOCK.
module rom_port_arbiter #(
  parameter int ADDR_W   = 9,
  parameter int DATA_W   = 32,
  parameter int MAX_LOCK = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              r0_req,
  input  logic [ADDR_W-1:0] r0_addr,
  output logic              r0_gnt,
  output logic              r0_valid,
  output logic [DATA_W-1:0] r0_data,
  input  logic              r1_req,
  input  logic [ADDR_W-1:0] r1_addr,
  output logic              r1_gnt,
  output logic              r1_valid,
  output logic [DATA_W-1:0] r1_data,
`ifdef ROM_ARB_LOCK_EN
  input  logic              r0_lock,
`endif
  output logic              rom_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_do
);

  typedef enum logic {
    LAST_R0 = 1'b0,
    LAST_R1 = 1'b1
  } last_t;

  last_t last;
  logic  tag_valid;
  logic  tag_id;
  logic  pick_r0;
  logic  pick_r1;
  logic  lock_hold;
  logic  lock_yield;

`ifdef ROM_ARB_LOCK_EN
  localparam int CNT_W = $clog2(MAX_LOCK + 1);

  logic [CNT_W-1:0] lock_cnt;

  // A nonzero count means the previous grant was a locked r0 grant, so r0 keeps the port.
  assign lock_hold  = r0_lock && (lock_cnt != '0);
  assign lock_yield = lock_hold && (lock_cnt == CNT_W'(MAX_LOCK));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_cnt <= '0;
    end else if (!r0_lock || !r0_req || r1_gnt) begin
      lock_cnt <= '0;
    end else if (r0_gnt && (lock_cnt != CNT_W'(MAX_LOCK))) begin
      lock_cnt <= lock_cnt + 1'b1;
    end
  end
`else
  assign lock_hold  = 1'b0;
  assign lock_yield = 1'b0;
`endif

  always_comb begin
    pick_r0 = 1'b0;
    pick_r1 = 1'b0;
    if (r0_req && r1_req) begin
      if (lock_hold) begin
        pick_r0 = !lock_yield;
        pick_r1 = lock_yield;
      end else if (last == LAST_R1) begin
        pick_r0 = 1'b1;
      end else begin
        pick_r1 = 1'b1;
      end
    end else if (r0_req) begin
      pick_r0 = 1'b1;
    end else if (r1_req) begin
      pick_r1 = 1'b1;
    end
  end

  assign r0_gnt   = pick_r0 && rst_n;
  assign r1_gnt   = pick_r1 && rst_n;
  assign rom_en   = r0_gnt || r1_gnt;
  assign rom_addr = r0_gnt ? r0_addr : (r1_gnt ? r1_addr : '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last <= LAST_R1;
    end else if (r0_gnt) begin
      last <= LAST_R0;
    end else if (r1_gnt) begin
      last <= LAST_R1;
    end
  end

  // Tag follows the ROM's one-cycle latency so the returned word reaches its issuer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_valid <= 1'b0;
      tag_id    <= 1'b0;
    end else begin
      tag_valid <= rom_en;
      tag_id    <= r1_gnt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r0_valid <= 1'b0;
      r1_valid <= 1'b0;
      r0_data  <= '0;
      r1_data  <= '0;
    end else begin
      r0_valid <= tag_valid && !tag_id;
      r1_valid <= tag_valid && tag_id;
      if (tag_valid && !tag_id) begin
        r0_data <= rom_do;
      end
      if (tag_valid && tag_id) begin
        r1_data <= rom_do;
      end
    end
  end

endmodule
